// File: rtl/fifo_pkg.sv
// fifo_pkg: width helpers and default parameters shared by the multi-push FIFO files.
package fifo_pkg;

    localparam int MPF_WIDTH = 8;
    localparam int MPF_DEPTH = 8;
    localparam int MPF_NPSH  = 4;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ptr_add.sv
// fifo_ptr_add: (ptr + inc) mod DEPTH for any DEPTH; needs ptr < DEPTH and inc <= DEPTH.
module fifo_ptr_add #(
    parameter int DEPTH = 8,
    parameter int PW    = 3,
    parameter int IW    = 3
) (
    input  logic [PW-1:0] ptr,
    input  logic [IW-1:0] inc,
    output logic [PW-1:0] sum
);

    localparam int SW = ((PW > IW) ? PW : IW) + 1;

    logic [SW-1:0] s;

    // The raw sum is below 2*DEPTH, so a single conditional subtract wraps it.
    assign s   = SW'(ptr) + SW'(inc);
    assign sum = (s >= SW'(DEPTH)) ? PW'(s - SW'(DEPTH)) : PW'(s);

endmodule

// File: rtl/mpush_fifo.sv
// mpush_fifo: FIFO accepting up to NPSH words per cycle, single pop, fall-through head.
// Define MPUSH_FIFO_ERR_EN to build the sticky err flag for rejected pushes and empty pops.
module mpush_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH = MPF_WIDTH,
    parameter int DEPTH = MPF_DEPTH,
    parameter int NPSH  = MPF_NPSH
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              psh,
    input  logic [cnt_w(NPSH)-1:0]            psh_cnt,
    input  logic [NPSH-1:0][WIDTH-1:0]        din,
    input  logic                              pop,
    output logic [WIDTH-1:0]                  dout,
    output logic                              dout_val,
    output logic                              full,
    output logic [cnt_w(DEPTH)-1:0]           free_cnt,
    output logic                              err
);

    localparam int PW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam int NW = cnt_w(NPSH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rptr, wptr, rptr_nxt, wptr_nxt;
    logic [PW-1:0]    laddr [NPSH];
    logic [CW-1:0]    count, count_nxt;
    logic             psh_ok, pop_ok;

    // Space is judged on registered state only; a same-cycle pop never frees room.
    assign free_cnt  = CW'(DEPTH) - count;
    assign psh_ok    = psh && (psh_cnt != '0) && (CW'(psh_cnt) <= free_cnt);
    assign pop_ok    = pop && (count != '0);
    assign count_nxt = count + (psh_ok ? CW'(psh_cnt) : '0) - CW'(pop_ok);

    assign dout_val = (count != '0);
    assign full     = (free_cnt < CW'(NPSH));
    assign dout     = dout_val ? mem[rptr] : '0;

    for (genvar g = 0; g < NPSH; g++) begin : g_lane
        fifo_ptr_add #(.DEPTH(DEPTH), .PW(PW), .IW(NW)) u_lane (
            .ptr (wptr),
            .inc (NW'(g)),
            .sum (laddr[g])
        );
    end

    fifo_ptr_add #(.DEPTH(DEPTH), .PW(PW), .IW(NW)) u_wadv (
        .ptr (wptr),
        .inc (psh_cnt),
        .sum (wptr_nxt)
    );

    fifo_ptr_add #(.DEPTH(DEPTH), .PW(PW), .IW(1)) u_radv (
        .ptr (rptr),
        .inc (1'b1),
        .sum (rptr_nxt)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < NPSH; i++)
            if (psh_ok && (i < int'(psh_cnt)))
                mem[laddr[i]] <= din[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (psh_ok)
                wptr <= wptr_nxt;
            if (pop_ok)
                rptr <= rptr_nxt;
            count <= count_nxt;
        end
    end

`ifdef MPUSH_FIFO_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= 1'b0;
        else if ((psh && (psh_cnt != '0) && !psh_ok) || (pop && !pop_ok))
            err_q <= 1'b1;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mpush_fifo.sv
// tb_mpush_fifo: directed checks of mpush_fifo at WIDTH=8, DEPTH=6, NPSH=4.
module tb_mpush_fifo;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            psh = 1'b0;
    logic [2:0]      psh_cnt = '0;
    logic [3:0][7:0] din = '0;
    logic            pop = 1'b0;
    logic [7:0]      dout;
    logic            dout_val, full, err;
    logic [2:0]      free_cnt;

    int passed = 0;
    int total  = 0;

`ifdef MPUSH_FIFO_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    mpush_fifo #(.WIDTH(8), .DEPTH(6), .NPSH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .psh      (psh),
        .psh_cnt  (psh_cnt),
        .din      (din),
        .pop      (pop),
        .dout     (dout),
        .dout_val (dout_val),
        .full     (full),
        .free_cnt (free_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic [7:0] exp_q [$];

    initial begin
        #12;
        chk("rst_dout_val", 32'(dout_val), 0);
        chk("rst_free", 32'(free_cnt), 6);
        chk("rst_full", 32'(full), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_dout", 32'(dout), 0);
        rst_n = 1'b1;
        step();

        psh = 1'b1; psh_cnt = 3'd3; din = {8'h00, 8'h33, 8'h22, 8'h11};
        step();
        psh = 1'b0;
        chk("p3_dout", 32'(dout), 32'h11);
        chk("p3_free", 32'(free_cnt), 3);
        chk("p3_full", 32'(full), 1);
        pop = 1'b1;
        step();
        chk("pop1_dout", 32'(dout), 32'h22);
        step();
        chk("pop2_dout", 32'(dout), 32'h33);
        step();
        pop = 1'b0;
        chk("pop3_val", 32'(dout_val), 0);
        chk("pop3_dout", 32'(dout), 0);

        psh = 1'b1; psh_cnt = 3'd4; din = {8'hA4, 8'hA3, 8'hA2, 8'hA1};
        step();
        psh = 1'b0;
        chk("p4_free", 32'(free_cnt), 2);
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        pop = 1'b1;
        foreach (exp_q[i]) begin
            chk("wrap_pop_a", 32'(dout), 32'(exp_q[i]));
            step();
        end
        pop = 1'b0;
        psh = 1'b1; psh_cnt = 3'd4; din = {8'hB4, 8'hB3, 8'hB2, 8'hB1};
        step();
        psh = 1'b0;
        chk("wrap_free", 32'(free_cnt), 1);
        exp_q = '{8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
        pop = 1'b1;
        foreach (exp_q[i]) begin
            chk("wrap_pop_b", 32'(dout), 32'(exp_q[i]));
            step();
        end
        pop = 1'b0;
        chk("wrap_end_free", 32'(free_cnt), 6);
        chk("wrap_end_err", 32'(err), 0);

        psh = 1'b1; psh_cnt = 3'd3; din = {8'h00, 8'hC3, 8'hC2, 8'hC1};
        step();
        psh_cnt = 3'd4; din = {8'hEE, 8'hEE, 8'hEE, 8'hEE};
        step();
        psh = 1'b0;
        chk("rej_free", 32'(free_cnt), 3);
        chk("rej_dout", 32'(dout), 32'hC1);
        chk("rej_err", 32'(err), 32'(ERR_ON));

        pop = 1'b1;
        step();
        psh = 1'b1; psh_cnt = 3'd4; din = {8'hD4, 8'hD3, 8'hD2, 8'hD1};
        step();
        psh = 1'b0;
        chk("pp_free", 32'(free_cnt), 1);
        chk("pp_full", 32'(full), 1);
        exp_q = '{8'hC3, 8'hD1, 8'hD2, 8'hD3, 8'hD4};
        foreach (exp_q[i]) begin
            chk("pp_pop", 32'(dout), 32'(exp_q[i]));
            step();
        end
        chk("pp_empty_val", 32'(dout_val), 0);
        chk("empty_pop_free", 32'(free_cnt), 6);
        step();
        pop = 1'b0;
        chk("empty_pop_val", 32'(dout_val), 0);
        chk("empty_pop_err", 32'(err), 32'(ERR_ON));

        psh = 1'b1; psh_cnt = 3'd0; din = {8'h99, 8'h99, 8'h99, 8'h99};
        step();
        chk("cnt0_free", 32'(free_cnt), 6);
        psh_cnt = 3'd1; din = {8'h00, 8'h00, 8'h00, 8'hE1};
        step();
        psh = 1'b0;
        chk("after_empty_dout", 32'(dout), 32'hE1);
        chk("after_empty_free", 32'(free_cnt), 5);
        pop = 1'b1;
        step();
        pop = 1'b0;

        psh = 1'b1; psh_cnt = 3'd4; din = {8'hF4, 8'hF3, 8'hF2, 8'hF1};
        step();
        psh = 1'b0;
        chk("pre_rst_val", 32'(dout_val), 1);
        chk("pre_rst_free", 32'(free_cnt), 2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_val", 32'(dout_val), 0);
        chk("async_rst_free", 32'(free_cnt), 6);
        chk("async_rst_full", 32'(full), 0);
        chk("async_rst_err", 32'(err), 0);
        chk("async_rst_dout", 32'(dout), 0);
        step();
        rst_n = 1'b1;
        step();
        chk("post_rst_val", 32'(dout_val), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mpush_fifo.md
MPUSH_FIFO -- requirements
Module: mpush_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning storage entries; legal range DEPTH >= NPSH, any integer, not restricted to powers of two.
REQ-003 SHALL have parameter NPSH, default 4, meaning maximum words accepted per push cycle.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset; asynchronous, active-low.
REQ-006 SHALL have port psh, input, 1, meaning push request this cycle.
REQ-007 SHALL have port psh_cnt, input, $clog2(NPSH+1), meaning number of valid lanes in din (1..NPSH); psh with psh_cnt=0 is a no-op.
REQ-008 SHALL have port din, input, [NPSH-1:0][WIDTH-1:0], meaning push lanes; lane 0 is oldest.
REQ-009 SHALL have port pop, input, 1, meaning consume head word.
REQ-010 SHALL have port dout, output, WIDTH, meaning head word.
REQ-011 SHALL have port dout_val, output, 1, meaning FIFO non-empty.
REQ-012 SHALL have port full, output, 1, meaning free entries < NPSH.
REQ-013 SHALL have port free_cnt, output, $clog2(DEPTH+1), meaning free entries.
REQ-014 SHALL have port err, output, 1, meaning sticky error flag (see Configuration).

Function
REQ-015 SHALL accept a push iff psh && psh_cnt != 0 && psh_cnt <= free_cnt (registered value; a same-cycle pop does not add space).
REQ-016 SHALL write lanes 0..psh_cnt-1 to wptr, wptr+1, ... modulo DEPTH in one cycle, then advance wptr by psh_cnt modulo DEPTH.
REQ-017 SHALL drop a rejected push entirely (no partial write, no pointer or count change).
REQ-018 SHALL honour pop iff dout_val=1; pop when empty is ignored, with no pointer or count change.
REQ-019 SHALL advance rptr by 1 modulo DEPTH on an honoured pop.
REQ-020 SHALL update count as count + accepted_psh_cnt - honoured_pop in one cycle; push and pop may occur in the same cycle.
REQ-021 SHALL drive dout combinationally from the entry at rptr (first-word fall-through); pushed data is visible on dout the cycle after the push.
REQ-022 SHALL drive dout = 0 when empty.
REQ-023 SHALL derive dout_val = (count != 0), full = (DEPTH - count < NPSH), free_cnt = DEPTH - count, all from registered state.
REQ-024 SHALL never let count exceed DEPTH; the count register is $clog2(DEPTH+1) bits wide.

Reset
REQ-025 SHALL, on rst_n low, asynchronously clear rptr, wptr, count and err, with outputs dout=0, dout_val=0, full=0, free_cnt=DEPTH, err=0.
REQ-026 SHALL NOT reset the storage array; a reset mid-operation discards all contents.
REQ-027 SHALL ignore a psh or pop in the first edge after reset release only if rst_n is still low at that edge.

Configuration
REQ-028 SHALL, with MPUSH_FIFO_ERR_EN defined, set err on a rejected push (psh, psh_cnt != 0, psh_cnt > free_cnt) or a pop when empty; err stays set until reset.
REQ-029 SHALL, without MPUSH_FIFO_ERR_EN, tie err to 0 and synthesise no error logic.

Structure
REQ-030 SHALL place a shared package fifo_pkg holding the pointer-width and count-width helper functions and the mpush_fifo default parameter constants.
REQ-031 SHALL use one sub-module, fifo_ptr_add, computing (ptr + inc) modulo DEPTH without a power-of-two assumption; it is instantiated for wptr advance, per-lane write addresses and rptr advance.

Verification (WIDTH=8, DEPTH=6, NPSH=4)
REQ-032 SHALL cover: reset -> dout_val=0, free_cnt=6, full=0, err=0.
REQ-033 SHALL cover: push psh_cnt=3 of {0x11,0x22,0x33} -> next cycle dout=0x11, free_cnt=3, full=1; three pops -> dout 0x22, then 0x33, then dout_val=0.
REQ-034 SHALL cover: push 4, pop 3, push 4 (wrap across index 5->0) -> all 5 words popped in push order; free_cnt=6 at end.
REQ-035 SHALL cover: with 3 entries held, push psh_cnt=4 -> rejected, count unchanged, err=1 only when MPUSH_FIFO_ERR_EN is defined.
REQ-036 SHALL cover: 2 entries held, same cycle push psh_cnt=4 and pop -> push accepted, pop honoured, free_cnt=1.
REQ-037 SHALL cover: pop when empty -> no state change; rst_n asserted mid-stream with 4 entries -> dout_val=0 immediately, without waiting for a clock edge.
